if_id_pipe_reg: RTL and testbench
=================================

// Module: if_id_pipe_reg
// PURPOSE
// IF/ID pipeline register of the 5-stage pipelined ARM CPU. Captures the fetched instruction, its PC and
// PC+4 from instruction fetch each cycle and presents them to instruction decode. Supports hazard-unit
// stall (hold contents) and branch flush (insert NOP bubble), and keeps saturating stall/bubble counters.
// PARAMETERS
// NOP_INSTR  32'hD503201F  encoding loaded into id_opcode on reset and on flush
// CNT_W      16            width of stall_count and bubble_count
// PORTS
// clk           in   1      rising-edge clock
// reset         in   1      asynchronous, active-high reset
// if_opcode     in   32     instruction from instruction memory
// if_pc         in   64     PC of if_opcode
// if_incr4      in   64     PC+4 of if_opcode
// stall         in   1      hazard unit: hold IF/ID contents this cycle
// flush         in   1      branch taken in ID: discard fetched instruction
// id_opcode     out  32     registered instruction to decode
// id_pc         out  64     registered PC
// id_incr4      out  64     registered PC+4 (BL link value)
// id_valid      out  1      1 = id_opcode is a real instruction, 0 = bubble
// stall_count   out  CNT_W  saturating count of cycles with stall asserted and flush low
// bubble_count  out  CNT_W  saturating count of bubbles inserted by flush
// BEHAVIOUR
// - Reset (async, immediate, any cycle incl. mid-stall): id_opcode=NOP_INSTR, id_pc=0, id_incr4=0,
//   id_valid=0, stall_count=0, bubble_count=0. First rising edge after reset deasserts captures normally.
// - Latency: 1 cycle; outputs change only on rising clk (or reset). No combinational in->out paths.
// - Per edge, priority flush > stall > load:
//   LOAD  (flush=0, stall=0): id_opcode<=if_opcode, id_pc<=if_pc, id_incr4<=if_incr4, id_valid<=1.
//   STALL (flush=0, stall=1): all data outputs and id_valid hold; stall_count+=1.
//   FLUSH (flush=1, any stall): id_opcode<=NOP_INSTR, id_pc<=0, id_incr4<=0, id_valid<=0;
//     bubble_count+=1; stall_count unchanged (branch redirect overrides hazard hold).
// - Consecutive flushes each insert one bubble and each increment bubble_count.
// - Stall while id_valid=0 holds the bubble (id_valid stays 0); still counts in stall_count.
// - Counters saturate at all-ones (2^CNT_W-1); never wrap. Only reset clears them.
// - if_opcode/if_pc/if_incr4 are don't-care during STALL and FLUSH; X on them must not reach outputs.
// - Built from per-bit D flip-flops with enable/mux gating, structural like the rest of the datapath;
//   the 64-bit fields use the same register-with-enable construction as the PC register.
// TESTING
// 1 reset asserted mid-cycle with stall=1 -> outputs immediately NOP_INSTR/0/0, id_valid=0, counters 0.
// 2 load if_opcode=32'h91000421, if_pc=64'h10, if_incr4=64'h14 -> next edge id_* match, id_valid=1.
// 3 after load, stall=1 for 3 edges while inputs change to 32'hDEADBEEF -> id_* hold 32'h91000421/0x10/0x14;
//   stall_count=3.
// 4 flush=1 and stall=1 same edge -> id_opcode=32'hD503201F, id_pc=0, id_valid=0, bubble_count=1,
//   stall_count unchanged.
// 5 CNT_W=4, hold stall=1 for 20 edges -> stall_count reaches 15 and stays 15.
// 6 flush on 2 consecutive edges then load 32'hB4000040 at pc 0x20 -> bubble_count=2, then id_valid=1
//   with id_opcode=32'hB4000040, id_pc=0x20, id_incr4=0x24.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: carries the fetched instruction, its PC and PC+4 into decode,
// with hazard stall (hold), branch flush (NOP bubble) and saturating stall/bubble counters.

// Single D flip-flop with load enable; the primitive every datapath register is built from.
module if_id_dff (
   input  logic clk,
   input  logic reset,
   input  logic rst_val,
   input  logic en,
   input  logic d,
   output logic q
);
   // NOTE: the reset is in the sensitivity list so it acts immediately, not at the next edge.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
      if (reset)
         q <= rst_val;
      else if (en)
         q <= d;
   end
endmodule

// W-bit register with enable, one if_id_dff per bit, same construction as the PC register.
module if_id_reg_en #(
   parameter int             W       = 64,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   localparam logic [W-1:0] RV = RST_VAL;

   for (genvar i = 0; i < W; i++) begin : g_bit
      if_id_dff u_bit (
         .clk     (clk),
         .reset   (reset),
         .rst_val (RV[i]),
         .en      (en),
         .d       (d[i]),
         .q       (q[i])
      );
   end
endmodule

module if_id_pipe_reg #(
   parameter logic [31:0] NOP_INSTR = 32'hD503201F,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      if_opcode,
   input  logic [63:0]      if_pc,
   input  logic [63:0]      if_incr4,
   input  logic             stall,
   input  logic             flush,
   output logic [31:0]      id_opcode,
   output logic [63:0]      id_pc,
   output logic [63:0]      id_incr4,
   output logic             id_valid,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] bubble_count
);
   logic             load_en;
   logic [31:0]      opcode_d;
   logic [63:0]      pc_d;
   logic [63:0]      incr4_d;
   logic             valid_d;
   logic             stall_en;
   logic             bubble_en;
   logic [CNT_W-1:0] stall_count_d;
   logic [CNT_W-1:0] bubble_count_d;

   // Flush wins over stall: the mux forces the bubble, so X on the fetch inputs never propagates.
   assign load_en  = flush | ~stall;
   assign opcode_d = flush ? NOP_INSTR : if_opcode;
   assign pc_d     = flush ? 64'd0     : if_pc;
   assign incr4_d  = flush ? 64'd0     : if_incr4;
   assign valid_d  = ~flush;

   // Counters stop at all-ones; only reset clears them.
   assign stall_en       = stall & ~flush & ~(&stall_count);
   assign bubble_en      = flush & ~(&bubble_count);
   assign stall_count_d  = stall_count  + CNT_W'(1);
   assign bubble_count_d = bubble_count + CNT_W'(1);

   if_id_reg_en #(.W(32), .RST_VAL(NOP_INSTR)) u_opcode (
      .clk(clk), .reset(reset), .en(load_en), .d(opcode_d), .q(id_opcode)
   );

   if_id_reg_en #(.W(64), .RST_VAL(64'd0)) u_pc (
      .clk(clk), .reset(reset), .en(load_en), .d(pc_d), .q(id_pc)
   );

   if_id_reg_en #(.W(64), .RST_VAL(64'd0)) u_incr4 (
      .clk(clk), .reset(reset), .en(load_en), .d(incr4_d), .q(id_incr4)
   );

   if_id_reg_en #(.W(1), .RST_VAL(1'b0)) u_valid (
      .clk(clk), .reset(reset), .en(load_en), .d(valid_d), .q(id_valid)
   );

   if_id_reg_en #(.W(CNT_W), .RST_VAL('0)) u_stall_cnt (
      .clk(clk), .reset(reset), .en(stall_en), .d(stall_count_d), .q(stall_count)
   );

   if_id_reg_en #(.W(CNT_W), .RST_VAL('0)) u_bubble_cnt (
      .clk(clk), .reset(reset), .en(bubble_en), .d(bubble_count_d), .q(bubble_count)
   );
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: a 16-bit-counter instance and a 4-bit-counter instance
// share stimulus; a behavioural model queues expected outputs that are compared after each edge.
module tb_if_id_pipe_reg;
   localparam logic [31:0] NOP = 32'hD503201F;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_opcode;
   logic [63:0] if_pc;
   logic [63:0] if_incr4;
   logic        stall;
   logic        flush;

   logic [31:0] id_opcode,  id_opcode4;
   logic [63:0] id_pc,      id_pc4;
   logic [63:0] id_incr4,   id_incr44;
   logic        id_valid,   id_valid4;
   logic [15:0] stall_count, bubble_count;
   logic [3:0]  stall_count4, bubble_count4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   if_id_pipe_reg #(.NOP_INSTR(NOP), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .if_opcode(if_opcode), .if_pc(if_pc), .if_incr4(if_incr4),
      .stall(stall), .flush(flush), .id_opcode(id_opcode), .id_pc(id_pc), .id_incr4(id_incr4),
      .id_valid(id_valid), .stall_count(stall_count), .bubble_count(bubble_count)
   );

   if_id_pipe_reg #(.NOP_INSTR(NOP), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .if_opcode(if_opcode), .if_pc(if_pc), .if_incr4(if_incr4),
      .stall(stall), .flush(flush), .id_opcode(id_opcode4), .id_pc(id_pc4), .id_incr4(id_incr44),
      .id_valid(id_valid4), .stall_count(stall_count4), .bubble_count(bubble_count4)
   );

   typedef struct packed {
      logic [31:0] op;
      logic [63:0] pc;
      logic [63:0] inc;
      logic        v;
      logic [15:0] sc;
      logic [15:0] bc;
      logic [3:0]  sc4;
      logic [3:0]  bc4;
      logic        same4;
   } obs_t;

   obs_t sb[$];
   obs_t exp_o, act_o;

   // Reference model state
   logic [31:0] m_op;
   logic [63:0] m_pc, m_inc;
   logic        m_v;
   logic [15:0] m_sc, m_bc;
   logic [3:0]  m_sc4, m_bc4;

   function automatic obs_t model_obs();
      obs_t o;
      o.op = m_op; o.pc = m_pc; o.inc = m_inc; o.v = m_v;
      o.sc = m_sc; o.bc = m_bc; o.sc4 = m_sc4; o.bc4 = m_bc4; o.same4 = 1'b1;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.op = id_opcode; o.pc = id_pc; o.inc = id_incr4; o.v = id_valid;
      o.sc = stall_count; o.bc = bubble_count; o.sc4 = stall_count4; o.bc4 = bubble_count4;
      o.same4 = (id_opcode4 === id_opcode) && (id_pc4 === id_pc) &&
                (id_incr44 === id_incr4) && (id_valid4 === id_valid);
      return o;
   endfunction

   task automatic model_reset();
      m_op = NOP; m_pc = '0; m_inc = '0; m_v = 1'b0;
      m_sc = '0; m_bc = '0; m_sc4 = '0; m_bc4 = '0;
   endtask

   // Drive one cycle of stimulus, queue the model's post-edge expectation, advance past the edge.
   task automatic step(input logic s, input logic f, input logic [31:0] op,
                       input logic [63:0] pc, input logic [63:0] inc);
      stall = s; flush = f; if_opcode = op; if_pc = pc; if_incr4 = inc;
      if (f) begin
         m_op = NOP; m_pc = '0; m_inc = '0; m_v = 1'b0;
         if (m_bc  != 16'hFFFF) m_bc  = m_bc  + 16'd1;
         if (m_bc4 != 4'hF)     m_bc4 = m_bc4 + 4'd1;
      end else if (s) begin
         if (m_sc  != 16'hFFFF) m_sc  = m_sc  + 16'd1;
         if (m_sc4 != 4'hF)     m_sc4 = m_sc4 + 4'd1;
      end else begin
         m_op = op; m_pc = pc; m_inc = inc; m_v = 1'b1;
      end
      sb.push_back(model_obs());
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      stall = 1'b0; flush = 1'b0; if_opcode = '0; if_pc = '0; if_incr4 = '0;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 32'h12345678, 64'h100, 64'h104);
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL pre_reset_load: got %h want %h", act_o, exp_o);
      end
      step(1'b1, 1'b0, 32'hCAFEF00D, 64'h200, 64'h204);
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL pre_reset_stall: got %h want %h", act_o, exp_o);
      end
      // Assert reset mid-cycle while stall is still high; outputs must clear before any edge.
      #2 reset = 1'b1;
      model_reset();
      #1;
      sb.push_back(model_obs());
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", act_o, exp_o);
      end
      @(posedge clk);
      #1;
      sb.push_back(model_obs());
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL reset_held: got %h want %h", act_o, exp_o);
      end
      reset = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_load();
      step(1'b0, 1'b0, 32'h91000421, 64'h10, 64'h14);
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL load: got %h want %h", act_o, exp_o);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'hDEADBEEF, 'x, 64'hDEAD_0000 + 64'(i));
         exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
         if (act_o !== exp_o) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: got %h want %h", i, act_o, exp_o);
         end
      end
   endtask

   task automatic test_flush_stall();
      step(1'b1, 1'b1, 'x, 'x, 'x);
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL flush_over_stall: got %h want %h", act_o, exp_o);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 32'h0BAD0BAD, 64'h0, 64'h4);
         exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
         if (act_o !== exp_o) begin
            n_bad++;
            $display("FAIL stall_saturate[%0d]: got %h want %h", i, act_o, exp_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 32'h11111111, 64'h40, 64'h44);
         exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
         if (act_o !== exp_o) begin
            n_bad++;
            $display("FAIL b2b_flush[%0d]: got %h want %h", i, act_o, exp_o);
         end
      end
      // Stall while a bubble sits in IF/ID: the bubble holds and the stall still counts.
      step(1'b1, 1'b0, 'x, 'x, 'x);
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL stall_on_bubble: got %h want %h", act_o, exp_o);
      end
      step(1'b0, 1'b0, 32'hB4000040, 64'h20, 64'h24);
      exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
      if (act_o !== exp_o) begin
         n_bad++;
         $display("FAIL load_after_flush: got %h want %h", act_o, exp_o);
      end
   endtask

   task automatic test_random();
      logic [63:0] pc;
      for (int i = 0; i < 40; i++) begin
         pc = {32'h0, $urandom} & 64'hFFFF_FFFC;
         step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              $urandom, pc, pc + 64'd4);
         exp_o = sb.pop_front(); act_o = sample(); n_cmp++;
         if (act_o !== exp_o) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h want %h", i, act_o, exp_o);
         end
      end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_load();
      test_stall();
      test_flush_stall();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
